alu_mult_seq: RTL and testbench
===============================

ALU_MULT_SEQ -- requirements
Module: alu_mult_seq

Interface
REQ-001 The block SHALL have a single clock, `clock`, and reset, `reset`, which is synchronous and active-high.
REQ-002 Parameter: COUNT_W, default 5, width of the bit-index counter; only value 5 is supported.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 ctrl_MULT  input  1  start pulse, sampled on the clock edge.
REQ-006 data_operandA  input  32  multiplicand, signed two's complement, latched at start.
REQ-007 data_operandB  input  32  multiplier, signed two's complement, latched at start.
REQ-008 alu_operandA  output  32  ALU operand A drive.
REQ-009 alu_operandB  output  32  ALU operand B drive.
REQ-010 alu_opcode  output  5  ALU opcode: ADD = 5'd0, SUB = 5'd1.
REQ-011 alu_shamt  output  5  ALU shift amount, always 0.
REQ-012 alu_result  input  32  combinational ALU result, same cycle.
REQ-013 alu_overflow  input  1  signed-add overflow flag from the ALU, same cycle.
REQ-014 data_result  output  32  product, low 32 bits.
REQ-015 data_exception  output  1  product does not fit in 32 signed bits.
REQ-016 data_resultRDY  output  1  one-cycle pulse when the result is valid.
REQ-017 busy  output  1  high from INIT through DONE inclusive.

Function
REQ-018 The FSM SHALL have the states IDLE, INIT, DBL, ADD and DONE; all state transitions occur on the rising edge of `clock`.
REQ-019 In IDLE with ctrl_MULT=1, the block SHALL latch A and B, set the counter to 30, clear the sticky exception, and go to INIT.
REQ-020 ctrl_MULT SHALL be ignored in every state other than IDLE.
REQ-021 In INIT the block SHALL drive the ALU as follows:
- If B[31]=1: drive SUB(0, A).
- Otherwise: drive ADD(0, 0).
REQ-022 In INIT the block SHALL load acc from alu_result, set exc = B[31] & (A==32'h80000000), and go to DBL.
REQ-023 In DBL the block SHALL drive ADD(acc, acc), load acc from alu_result, OR alu_overflow into exc, and go to ADD.
REQ-024 In ADD the block SHALL drive ADD(acc, B[count] ? A : 0), load acc from alu_result, and OR alu_overflow into exc.
REQ-025 From ADD the block SHALL go to DONE if count==0; otherwise it SHALL decrement count and go to DBL.
REQ-026 In DONE the block SHALL pulse data_resultRDY=1 for exactly one cycle, update data_result=acc and data_exception=exc, and go to IDLE.
REQ-027 Latency SHALL be fixed: with ctrl_MULT sampled on edge 0, data_resultRDY SHALL be high in the cycle following edge 64 (1 INIT + 31 DBL/ADD pairs + DONE), independent of operand values.
REQ-028 data_result and data_exception SHALL hold their values until the next DONE.
REQ-029 In IDLE and DONE the ALU drive SHALL be ADD(0, 0), and alu_shamt SHALL be 0 in every state.
REQ-030 alu_overflow SHALL be sampled only in DBL and ADD.
REQ-031 ctrl_MULT asserted in the DONE cycle SHALL be ignored; ctrl_MULT asserted in the IDLE cycle immediately after DONE SHALL be accepted.

Reset
REQ-032 When reset=1 the block SHALL go to IDLE and clear acc, count, exc, data_result, data_exception, data_resultRDY and busy to 0, from any state including mid-operation.
REQ-033 Reset SHALL take priority over ctrl_MULT in the same cycle; the aborted operation SHALL produce no data_resultRDY.

Structure
REQ-034 Package alu_pkg SHALL hold the ALU opcode constants (ADD, SUB, AND, OR, SLL, SRA = 0..5) and the FSM state enumeration.
REQ-035 No sub-module is warranted; the block SHALL be a single module containing the FSM, the counter, the operand/accumulator registers and the ALU drive mux.
REQ-036 The ALU SHALL be instantiated outside this block.

Verification
REQ-037 The bench SHALL connect a combinational ALU model with correct signed-add overflow.
REQ-038 Start with A=7, B=-6 -> data_resultRDY high exactly 64 edges after the start edge, data_result=32'hFFFFFFD6 (-42), data_exception=0.
REQ-039 Start with A=32'h40000000, B=2 -> data_result=32'h80000000, data_exception=1 (overflow raised by DBL).
REQ-040 Start with A=32'h80000000, B=-1 -> data_exception=1 (set in INIT); start with A=32'hC0000000, B=2 -> data_result=32'h80000000, data_exception=0.
REQ-041 Start with A=3, B=5, then pulse ctrl_MULT with A=9, B=9 at edge 10 -> exactly one data_resultRDY, data_result=15.
REQ-042 Start with A=3, B=5, assert reset at edge 20 -> busy=0 and all outputs 0 on the following cycle, and no data_resultRDY is produced.
REQ-043 After the reset in REQ-042, start with A=-4, B=-4 -> data_result=16, data_exception=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and the sequential multiplier state encoding.
package alu_pkg;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_SLL = 5'd4;
  localparam logic [4:0] ALU_SRA = 5'd5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_DBL  = 3'd2,
    ST_ADD  = 3'd3,
    ST_DONE = 3'd4
  } mult_state_e;

endpackage

// File: rtl/alu_mult_seq.sv
// Signed 32x32 shift-and-add multiplier that borrows an external ALU; fixed 64-cycle latency.
// The multiplier MSB carries weight -2^31, so INIT seeds acc with -A and the remaining bits are added MSB first.
module alu_mult_seq
  import alu_pkg::*;
#(
  parameter int COUNT_W = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] alu_operandA,
  output logic [31:0] alu_operandB,
  output logic [4:0]  alu_opcode,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  mult_state_e        state_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [31:0]        acc_q;
  logic [COUNT_W-1:0] count_q;
  logic               exc_q;
  logic [31:0]        result_q;
  logic               exc_out_q;
  logic               rdy_q;
  logic               busy_q;

  always_comb begin
    alu_operandA = 32'd0;
    alu_operandB = 32'd0;
    alu_opcode   = ALU_ADD;
    case (state_q)
      ST_INIT: begin
        if (b_q[31]) begin
          alu_opcode   = ALU_SUB;
          alu_operandB = a_q;
        end
      end
      ST_DBL: begin
        alu_operandA = acc_q;
        alu_operandB = acc_q;
      end
      ST_ADD: begin
        alu_operandA = acc_q;
        alu_operandB = b_q[count_q] ? a_q : 32'd0;
      end
      default: ;
    endcase
  end

  assign alu_shamt      = 5'd0;
  assign data_result    = result_q;
  assign data_exception = exc_out_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      acc_q     <= 32'd0;
      count_q   <= '0;
      exc_q     <= 1'b0;
      result_q  <= 32'd0;
      exc_out_q <= 1'b0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ctrl_MULT) begin
            a_q     <= data_operandA;
            b_q     <= data_operandB;
            count_q <= COUNT_W'(30);
            exc_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_INIT;
          end
        end
        ST_INIT: begin
          // -(-2^31) is the only negation that does not fit
          acc_q   <= alu_result;
          exc_q   <= b_q[31] & (a_q == 32'h8000_0000);
          state_q <= ST_DBL;
        end
        ST_DBL: begin
          acc_q   <= alu_result;
          exc_q   <= exc_q | alu_overflow;
          state_q <= ST_ADD;
        end
        ST_ADD: begin
          acc_q <= alu_result;
          exc_q <= exc_q | alu_overflow;
          if (count_q == '0) begin
            state_q <= ST_DONE;
          end else begin
            count_q <= count_q - 1'b1;
            state_q <= ST_DBL;
          end
        end
        ST_DONE: begin
          rdy_q     <= 1'b1;
          result_q  <= acc_q;
          exc_out_q <= exc_q;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed bench for alu_mult_seq with a combinational ALU model attached.
module tb_alu_mult_seq;
  import alu_pkg::*;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] alu_operandA;
  logic [31:0] alu_operandB;
  logic [4:0]  alu_opcode;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_mult_seq #(.COUNT_W(5)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .alu_operandA   (alu_operandA),
    .alu_operandB   (alu_operandB),
    .alu_opcode     (alu_opcode),
    .alu_shamt      (alu_shamt),
    .alu_result     (alu_result),
    .alu_overflow   (alu_overflow),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    alu_result   = 32'd0;
    alu_overflow = 1'b0;
    if (alu_opcode == ALU_SUB) begin
      alu_result   = alu_operandA - alu_operandB;
      alu_overflow = (alu_operandA[31] != alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
    end else begin
      alu_result   = alu_operandA + alu_operandB;
      alu_overflow = (alu_operandA[31] == alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Starts a multiply on edge 0, optionally holds ctrl_MULT high with other
  // operands for inj_len edges starting at edge inj_edge, and records the
  // edges after which data_resultRDY was observed.
  task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int inj_edge, input int inj_len,
                          input logic [31:0] inj_a, input logic [31:0] inj_b,
                          input int n_edges, output int n_rdy, output int rdy_edge0,
                          output int rdy_edge1, output logic [31:0] res0, output logic exc0);
    n_rdy = 0; rdy_edge0 = -1; rdy_edge1 = -1; res0 = 32'd0; exc0 = 1'b0;
    ctrl_MULT = 1'b1; data_operandA = a; data_operandB = b;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    check_val({tag, " busy"}, {31'd0, busy}, 32'd1);
    for (int e = 1; e <= n_edges; e++) begin
      if (e == inj_edge) begin
        ctrl_MULT = 1'b1; data_operandA = inj_a; data_operandB = inj_b;
      end
      if (inj_edge > 0 && e == inj_edge + inj_len) ctrl_MULT = 1'b0;
      @(posedge clock); #1;
      if (data_resultRDY) begin
        if (n_rdy == 0) begin
          rdy_edge0 = e; res0 = data_result; exc0 = data_exception;
        end else if (n_rdy == 1) begin
          rdy_edge1 = e;
        end
        n_rdy++;
      end
    end
    ctrl_MULT = 1'b0;
  endtask

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_exc;
  } vec_t;

  vec_t vecs[4];
  int   n_rdy, e0, e1;
  logic [31:0] r0;
  logic x0;

  initial begin
    vecs[0] = '{"7x-6",     32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0};
    vecs[1] = '{"4000x2",   32'h4000_0000, 32'd2,         32'h8000_0000, 1'b1};
    vecs[2] = '{"8000x-1",  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[3] = '{"C000x2",   32'hC000_0000, 32'd2,         32'h8000_0000, 1'b0};

    reset = 1'b1; ctrl_MULT = 1'b0; data_operandA = 32'd0; data_operandB = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    check_val("rst busy", {31'd0, busy}, 32'd0);
    check_val("rst rdy", {31'd0, data_resultRDY}, 32'd0);
    check_val("rst result", data_result, 32'd0);
    check_val("rst exc", {31'd0, data_exception}, 32'd0);
    check_val("rst shamt", {27'd0, alu_shamt}, 32'd0);
    check_val("rst opcode", {27'd0, alu_opcode}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    foreach (vecs[i]) begin
      run_mult(vecs[i].tag, vecs[i].a, vecs[i].b, 0, 0, 32'd0, 32'd0, 70, n_rdy, e0, e1, r0, x0);
      check_val({vecs[i].tag, " rdy count"}, n_rdy, 32'd1);
      check_val({vecs[i].tag, " latency"}, e0, 32'd64);
      check_val({vecs[i].tag, " result"}, r0, vecs[i].exp_res);
      check_val({vecs[i].tag, " exc"}, {31'd0, x0}, {31'd0, vecs[i].exp_exc});
      check_val({vecs[i].tag, " hold result"}, data_result, vecs[i].exp_res);
      check_val({vecs[i].tag, " idle busy"}, {31'd0, busy}, 32'd0);
    end

    // start ignored while busy
    run_mult("3x5 inj", 32'd3, 32'd5, 10, 1, 32'd9, 32'd9, 75, n_rdy, e0, e1, r0, x0);
    check_val("inj rdy count", n_rdy, 32'd1);
    check_val("inj latency", e0, 32'd64);
    check_val("inj result", r0, 32'd15);

    // start held through DONE (edge 64) and the following IDLE (edge 65)
    run_mult("done inj", 32'd3, 32'd5, 64, 2, 32'd2, 32'd3, 135, n_rdy, e0, e1, r0, x0);
    check_val("doneinj rdy count", n_rdy, 32'd2);
    check_val("doneinj first", e0, 32'd64);
    check_val("doneinj result", r0, 32'd15);
    check_val("doneinj second", e1, 32'd129);
    check_val("doneinj result2", data_result, 32'd6);

    // reset mid-operation
    run_mult("rst mid", 32'd3, 32'd5, 0, 0, 32'd0, 32'd0, 19, n_rdy, e0, e1, r0, x0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_val("rstmid busy", {31'd0, busy}, 32'd0);
    check_val("rstmid result", data_result, 32'd0);
    check_val("rstmid exc", {31'd0, data_exception}, 32'd0);
    check_val("rstmid rdy", {31'd0, data_resultRDY}, 32'd0);
    check_val("rstmid opA", alu_operandA, 32'd0);
    check_val("rstmid opB", alu_operandB, 32'd0);
    n_rdy = 0;
    for (int e = 0; e < 80; e++) begin
      @(posedge clock); #1;
      if (data_resultRDY) n_rdy++;
    end
    check_val("rstmid no rdy", n_rdy, 32'd0);

    run_mult("-4x-4", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0, 32'd0, 32'd0, 70, n_rdy, e0, e1, r0, x0);
    check_val("-4x-4 rdy count", n_rdy, 32'd1);
    check_val("-4x-4 latency", e0, 32'd64);
    check_val("-4x-4 result", r0, 32'd16);
    check_val("-4x-4 exc", {31'd0, x0}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
